// File: rtl/nanorv32_exit_monitor_pkg.sv
// Shared definitions for the nanorv32 exit monitor.
//   - mon_state_e : test status / FSM state encodings (RUN..TIMEOUT)
//   - con_entry_t : console FIFO entry {chan, data}
package nanorv32_exit_monitor_pkg;

  localparam int MON_STATUS_W = 3;
  localparam int CON_ENTRY_W  = 12;

  typedef enum logic [MON_STATUS_W-1:0] {
    MON_RUN     = 3'd0,
    MON_PASS    = 3'd1,
    MON_FAIL    = 3'd2,
    MON_UNKNOWN = 3'd3,
    MON_ILLEGAL = 3'd4,
    MON_TIMEOUT = 3'd5
  } mon_state_e;

  typedef struct packed {
    logic [3:0] chan;
    logic [7:0] data;
  } con_entry_t;

endpackage

// File: rtl/nanorv32_exit_monitor_sync_fifo.sv
// nanorv32_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   push_i, data_i      : write request / data (ignored when full unless popping)
//   pop_i               : consume head (ignored when empty)
//   data_o              : head entry, zero while empty
//   full_o, empty_o     : occupancy flags
//   count_o             : number of stored entries
module nanorv32_sync_fifo #(
  parameter  int unsigned WIDTH = 12,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // Gate the head so stale storage never shows up on the outputs.
  assign data_o = empty_o ? '0 : mem[rd_ptr_q];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/nanorv32_exit_monitor.sv
// nanorv32_exit_monitor: watches retired instructions and latches the final
// test status; captures console characters into a FWFT FIFO.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   inst_ret, pc, a0           : retire strobe, retired pc, x10 at retire
//   illegal_instruction        : decoder illegal flag (any cycle)
//   done, status, cycles       : sticky finish flag, result code, cycle count
//   con_valid/ready/data/chan  : console FIFO head handshake
//   con_eol                    : head character is newline
//   con_overflow               : sticky dropped-character flag
//   drained                    : done and console FIFO empty
module nanorv32_exit_monitor
  import nanorv32_exit_monitor_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] EXIT_PC        = 32'h0000_0100,
  parameter logic [DATA_W-1:0] PASS_MAGIC     = 32'hCAFF_E000,
  parameter logic [DATA_W-1:0] FAIL_MAGIC     = 32'hDEAD_0000,
  parameter logic [ADDR_W-1:0] CON_PC         = 32'h0000_0088,
  parameter int unsigned       NUM_CHAN       = 2,
  parameter int unsigned       FIFO_DEPTH     = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned       CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inst_ret,
  input  logic [ADDR_W-1:0]       pc,
  input  logic [DATA_W-1:0]       a0,
  input  logic                    illegal_instruction,
  output logic                    done,
  output logic [MON_STATUS_W-1:0] status,
  output logic [CNT_W-1:0]        cycles,
  output logic                    con_valid,
  input  logic                    con_ready,
  output logic [7:0]              con_data,
  output logic [3:0]              con_chan,
  output logic                    con_eol,
  output logic                    con_overflow,
  output logic                    drained
);

  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // One extra bit so the region end cannot wrap at the top of the address map.
  localparam logic [ADDR_W:0]   CON_LO  = {1'b0, CON_PC};
  localparam logic [ADDR_W:0]   CON_HI  = CON_LO + (ADDR_W+1)'(4 * NUM_CHAN);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             ovf_q, ovf_d;

  logic             is_exit, is_con, con_push;
  logic [ADDR_W:0]  pc_ext;
  logic [ADDR_W-1:0] con_off;
  con_entry_t       push_entry, head_entry;
  logic             fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign pc_ext  = {1'b0, pc};
  assign con_off = pc - CON_PC;
  assign is_exit = inst_ret && (pc == EXIT_PC);
  assign is_con  = inst_ret && (pc_ext >= CON_LO) && (pc_ext < CON_HI) &&
                   (pc[1:0] == CON_PC[1:0]);
  // Exit wins if the console window happens to cover EXIT_PC.
  assign con_push = (state_q == MON_RUN) && is_con && !is_exit;

  assign push_entry.chan = 4'(con_off >> 2);
  assign push_entry.data = a0[7:0];

  // Next-state: illegal > exit retire > timeout.
  always_comb begin
    state_d = state_q;
    if (state_q == MON_RUN) begin
      if (illegal_instruction)
        state_d = MON_ILLEGAL;
      else if (is_exit) begin
        if (a0 == PASS_MAGIC)      state_d = MON_PASS;
        else if (a0 == FAIL_MAGIC) state_d = MON_FAIL;
        else                       state_d = MON_UNKNOWN;
      end else if ((TIMEOUT_CYCLES != 0) && (cycles_q == TO_LAST))
        state_d = MON_TIMEOUT;
    end
  end

  // Counter stops on the terminal transition itself and saturates at all-ones.
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == MON_RUN) && (state_d == MON_RUN) && (cycles_q != '1))
      cycles_d = cycles_q + 1'b1;
  end

  // A full FIFO only drops the character when the head is not leaving too.
  always_comb begin
    ovf_d = ovf_q;
    if (con_push && fifo_full && !con_ready)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MON_RUN;
      cycles_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      ovf_q    <= ovf_d;
    end
  end

  nanorv32_sync_fifo #(
    .WIDTH (CON_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (con_push),
    .data_i  (push_entry),
    .pop_i   (con_ready),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign done         = (state_q != MON_RUN);
  assign status       = state_q;
  assign cycles       = cycles_q;
  assign con_valid    = !fifo_empty;
  assign con_data     = head_entry.data;
  assign con_chan     = head_entry.chan;
  assign con_eol      = con_valid && (head_entry.data == 8'h0A);
  assign con_overflow = ovf_q;
  assign drained      = done && fifo_empty && (fifo_count == '0);

endmodule

// File: tb/tb_nanorv32_exit_monitor.sv
module tb_nanorv32_exit_monitor;

  localparam logic [31:0] PASS_M = 32'hCAFF_E000;
  localparam logic [31:0] FAIL_M = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ret;
  logic [31:0] pc;
  logic [31:0] a0;
  logic        illegal_instruction;
  logic        con_ready;

  logic        done, con_valid, con_eol, con_overflow, drained;
  logic [2:0]  status;
  logic [31:0] cycles;
  logic [7:0]  con_data;
  logic [3:0]  con_chan;

  logic        to_done, to_con_valid, to_con_eol, to_con_overflow, to_drained;
  logic [2:0]  to_status;
  logic [31:0] to_cycles;
  logic [7:0]  to_con_data;
  logic [3:0]  to_con_chan;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  // Main DUT: small FIFO, no timeout.
  nanorv32_exit_monitor #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .inst_ret(inst_ret), .pc(pc), .a0(a0),
    .illegal_instruction(illegal_instruction),
    .done(done), .status(status), .cycles(cycles),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .con_chan(con_chan), .con_eol(con_eol), .con_overflow(con_overflow),
    .drained(drained));

  // Second DUT with a short timeout, shares stimulus.
  nanorv32_exit_monitor #(.TIMEOUT_CYCLES(50)) u_to (
    .clk(clk), .rst_n(rst_n), .inst_ret(inst_ret), .pc(pc), .a0(a0),
    .illegal_instruction(illegal_instruction),
    .done(to_done), .status(to_status), .cycles(to_cycles),
    .con_valid(to_con_valid), .con_ready(con_ready), .con_data(to_con_data),
    .con_chan(to_con_chan), .con_eol(to_con_eol), .con_overflow(to_con_overflow),
    .drained(to_drained));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    inst_ret = 1'b0; pc = '0; a0 = '0; illegal_instruction = 1'b0; con_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sb_q.delete();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] d);
    inst_ret = 1'b1; pc = p; a0 = d;
    step();
    inst_ret = 1'b0; pc = '0; a0 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    checks++; if ({done, status, cycles} !== 36'd0) begin errors++;
      $display("FAIL reset_status: got done=%0b status=%0d cycles=%0d want 0", done, status, cycles); end
    checks++; if ({con_valid, con_overflow, drained, con_eol, con_data, con_chan} !== 16'd0) begin errors++;
      $display("FAIL reset_console: got valid=%0b ovf=%0b drained=%0b data=%h want all 0",
               con_valid, con_overflow, drained, con_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    do_reset();
    step(); step(); step();
    checks++; if (status !== 3'd0 || done !== 1'b0) begin errors++;
      $display("FAIL pass_prerun: got status=%0d done=%0b want 0/0", status, done); end
    retire(32'h100, PASS_M);
    checks++; if (done !== 1'b1 || status !== 3'd1) begin errors++;
      $display("FAIL pass_status: got done=%0b status=%0d want 1/1", done, status); end
    checks++; if (cycles !== 32'd3) begin errors++;
      $display("FAIL pass_cycles: got %0d want 3", cycles); end
    repeat (5) step();
    checks++; if (cycles !== 32'd3 || status !== 3'd1) begin errors++;
      $display("FAIL pass_frozen: got cycles=%0d status=%0d want 3/1", cycles, status); end
  endtask

  task automatic test_fail_unknown();
    do_reset();
    pc = 32'h100; a0 = PASS_M; inst_ret = 1'b0;
    step();
    checks++; if (status !== 3'd0 || done !== 1'b0) begin errors++;
      $display("FAIL noret_exit: got status=%0d done=%0b want 0/0", status, done); end
    retire(32'h100, FAIL_M);
    checks++; if (status !== 3'd2 || done !== 1'b1) begin errors++;
      $display("FAIL fail_status: got status=%0d done=%0b want 2/1", status, done); end
    do_reset();
    retire(32'h100, 32'h1234_5678);
    checks++; if (status !== 3'd3 || done !== 1'b1) begin errors++;
      $display("FAIL unknown_status: got status=%0d done=%0b want 3/1", status, done); end
  endtask

  task automatic test_priority();
    do_reset();
    illegal_instruction = 1'b1;
    retire(32'h100, PASS_M);
    illegal_instruction = 1'b0;
    checks++; if (status !== 3'd4) begin errors++;
      $display("FAIL prio_illegal: got status=%0d want 4", status); end
    retire(32'h100, PASS_M);
    step();
    checks++; if (status !== 3'd4 || done !== 1'b1) begin errors++;
      $display("FAIL prio_sticky: got status=%0d done=%0b want 4/1", status, done); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (49) step();
    checks++; if (to_status !== 3'd0 || to_cycles !== 32'd49) begin errors++;
      $display("FAIL timeout_early: got status=%0d cycles=%0d want 0/49", to_status, to_cycles); end
    step();
    checks++; if (to_status !== 3'd5 || to_done !== 1'b1 || to_cycles !== 32'd49) begin errors++;
      $display("FAIL timeout_hit: got status=%0d done=%0b cycles=%0d want 5/1/49",
               to_status, to_done, to_cycles); end
    repeat (1000) step();
    checks++; if (status !== 3'd0 || done !== 1'b0 || cycles !== 32'd1050) begin errors++;
      $display("FAIL timeout_disabled: got status=%0d done=%0b cycles=%0d want 0/0/1050",
               status, done, cycles); end
    checks++; if (to_cycles !== 32'd49) begin errors++;
      $display("FAIL timeout_frozen: got cycles=%0d want 49", to_cycles); end
  endtask

  task automatic test_console();
    logic [11:0] exp;
    int n;
    do_reset();
    checks++; if (con_valid !== 1'b0) begin errors++;
      $display("FAIL con_empty: got valid=%0b want 0", con_valid); end
    retire(32'h88, 32'h48); sb_q.push_back({4'd0, 8'h48});
    checks++; if (con_valid !== 1'b1) begin errors++;
      $display("FAIL con_valid_rise: got valid=%0b want 1", con_valid); end
    retire(32'h8C, 32'h69); sb_q.push_back({4'd1, 8'h69});
    retire(32'h88, 32'h0A); sb_q.push_back({4'd0, 8'h0A});
    retire(32'h90, 32'h58);
    con_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      if (con_valid) begin
        exp = sb_q.pop_front();
        checks++; if (con_chan !== exp[11:8] || con_data !== exp[7:0]) begin errors++;
          $display("FAIL con_entry: got chan=%0d data=%h want chan=%0d data=%h",
                   con_chan, con_data, exp[11:8], exp[7:0]); end
        checks++; if (con_eol !== (exp[7:0] == 8'h0A)) begin errors++;
          $display("FAIL con_eol: got %0b want %0b", con_eol, exp[7:0] == 8'h0A); end
      end
      step();
      n++;
    end
    con_ready = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++;
      $display("FAIL con_drain_timeout: got %0d entries left want 0", sb_q.size()); end
    checks++; if (con_valid !== 1'b0) begin errors++;
      $display("FAIL con_no_extra: got valid=%0b want 0 (pc 0x90 must not push)", con_valid); end
  endtask

  task automatic test_overflow();
    logic [11:0] exp;
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        checks++; if (con_overflow !== 1'b0) begin errors++;
          $display("FAIL ovf_early: got %0b want 0", con_overflow); end
      end
      retire(32'h88, 32'(8'h41 + i));
      if (i < 4) sb_q.push_back({4'd0, 8'(8'h41 + i)});
    end
    checks++; if (con_overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_set: got %0b want 1", con_overflow); end
    repeat (3) step();
    checks++; if (con_valid !== 1'b1 || con_data !== sb_q[0][7:0]) begin errors++;
      $display("FAIL ovf_stable: got valid=%0b data=%h want 1/%h", con_valid, con_data, sb_q[0][7:0]); end
    // push and pop in the same cycle while full
    con_ready = 1'b1;
    exp = sb_q.pop_front();
    checks++; if (con_data !== exp[7:0]) begin errors++;
      $display("FAIL full_pushpop_head: got %h want %h", con_data, exp[7:0]); end
    retire(32'h88, 32'h5A);
    con_ready = 1'b0;
    sb_q.push_back({4'd0, 8'h5A});
    checks++; if (con_data !== sb_q[0][7:0] || con_overflow !== 1'b1) begin errors++;
      $display("FAIL full_pushpop: got data=%h ovf=%0b want %h/1", con_data, con_overflow, sb_q[0][7:0]); end
    retire(32'h100, PASS_M);
    checks++; if (done !== 1'b1 || status !== 3'd1 || drained !== 1'b0) begin errors++;
      $display("FAIL ovf_exit: got done=%0b status=%0d drained=%0b want 1/1/0", done, status, drained); end
    con_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      if (con_valid) begin
        exp = sb_q.pop_front();
        checks++; if (con_chan !== exp[11:8] || con_data !== exp[7:0]) begin errors++;
          $display("FAIL drain_entry: got chan=%0d data=%h want chan=%0d data=%h",
                   con_chan, con_data, exp[11:8], exp[7:0]); end
        step();
        checks++; if (drained !== (sb_q.size() == 0)) begin errors++;
          $display("FAIL drained_flag: got %0b want %0b", drained, sb_q.size() == 0); end
      end else step();
      n++;
    end
    con_ready = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++;
      $display("FAIL drain_timeout: got %0d entries left want 0", sb_q.size()); end
    retire(32'h88, 32'h51);
    checks++; if (con_valid !== 1'b0 || drained !== 1'b1) begin errors++;
      $display("FAIL push_after_done: got valid=%0b drained=%0b want 0/1", con_valid, drained); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_pass();
    test_fail_unknown();
    test_priority();
    test_timeout();
    test_console();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
